// File: rtl/neuron_core.sv
// neuron_core: three-stage neuron datapath (multiply, 33-term sum, activation).
// Activation is a step function by default; define NEURON_RELU_EN for a saturating ReLU.
module neuron_core (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0][31:0]  in_data,
  input  logic [32:0][31:0]  constant,
  output logic [63:0]        sum,
  output logic               out_valid,
  output logic [31:0]        out
);

  logic [32:0][31:0]  f_d, f_q;
  logic signed [63:0] acc_d, acc_q;
  logic [63:0]        sum_q;
  logic [31:0]        act_d, out_q;
  logic [2:0]         vld_q;

  // The low 32 bits of a 32x32 product are the same for signed and unsigned
  // operands, so a width-truncated multiply gives the wrapped signed result.
  always_comb begin
    f_d = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      f_d[i] = in_data[i] * constant[i];
    end
    f_d[32] = constant[32];
  end

  always_comb begin
    acc_d = '0;
    for (int unsigned i = 0; i < 33; i++) begin
      acc_d = acc_d + {{32{f_q[i][31]}}, f_q[i]};
    end
  end

`ifdef NEURON_RELU_EN
  always_comb begin
    act_d = '0;
    if (acc_q > 64'sh0000_0000_7FFF_FFFF) begin
      act_d = 32'h7FFF_FFFF;
    end else if (acc_q > 64'sd0) begin
      act_d = acc_q[31:0];
    end
  end
`else
  always_comb begin
    act_d = '0;
    if (acc_q > 64'sd0) begin
      act_d = 32'h0000_0001;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q   <= '0;
      acc_q <= '0;
      sum_q <= '0;
      out_q <= '0;
      vld_q <= '0;
    end else begin
      f_q   <= f_d;
      acc_q <= acc_d;
      sum_q <= acc_q;
      out_q <= act_d;
      vld_q <= {vld_q[1:0], in_valid};
    end
  end

  assign sum       = sum_q;
  assign out       = out_q;
  assign out_valid = vld_q[2];

endmodule

// File: tb/tb_neuron_core.sv
// Randomized and directed bench for neuron_core against a behavioural model.
// Follows NEURON_RELU_EN the same way the design does.
module tb_neuron_core;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [31:0][31:0] td;
  logic [32:0][31:0] tw;
  logic [63:0]       sum;
  logic              out_valid;
  logic [31:0]       out;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          v;
    longint      s;
    logic [31:0] o;
  } exp_t;

  exp_t hist[$];

  neuron_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (td),
    .constant  (tw),
    .sum       (sum),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint model_sum();
    longint s = 0;
    for (int i = 0; i < 32; i++) begin
      int a, w, p;
      a = td[i];
      w = tw[i];
      p = a * w;
      s += longint'(p);
    end
    s += longint'(int'(tw[32]));
    return s;
  endfunction

  function automatic logic [31:0] model_act(input longint s);
`ifdef NEURON_RELU_EN
    if (s <= 0) return 32'h0;
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    return s[31:0];
`else
    return (s > 0) ? 32'h1 : 32'h0;
`endif
  endfunction

  task automatic restart_model();
    exp_t b;
    b.v = 1'b0; b.s = 0; b.o = '0;
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
  endtask

  // One rising edge: record the vector just sampled, then compare the outputs
  // against the vector sampled two edges earlier.
  task automatic cycle();
    exp_t e, x;
    @(posedge clk);
    #1;
    e.v = in_valid;
    e.s = model_sum();
    e.o = model_act(e.s);
    hist.push_back(e);
    x = hist[hist.size() - 3];
    chk("out_valid", {63'd0, out_valid}, {63'd0, x.v});
    chk("sum", sum, x.s);
    chk("out", {32'd0, out}, {32'd0, x.o});
    while (hist.size() > 3) void'(hist.pop_front());
  endtask

  task automatic run_directed(input string tag, input longint es, input logic [31:0] eo);
    in_valid = 1'b1;
    repeat (3) cycle();
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_out"}, {32'd0, out}, {32'd0, eo});
    chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic bias_weights();
    for (int i = 0; i < 16; i++) tw[i] = 32'd4;
    for (int i = 16; i < 32; i++) tw[i] = -32'sd4;
    tw[32] = 32'd4;
  endtask

  task automatic rand_vec(input int mode);
    for (int i = 0; i < 32; i++) begin
      td[i] = (mode == 0) ? $urandom() : 32'($signed($urandom_range(0, 16)) - 8);
      tw[i] = (mode == 0) ? $urandom() : 32'($signed($urandom_range(0, 16)) - 8);
    end
    tw[32] = (mode == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
  endtask

  logic [31:0] k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; td = '0; tw = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_out", {32'd0, out}, 64'd0);
    #21;
    rst = 1'b0;
    restart_model();
    repeat (2) cycle();

    // Bias only
    td = '0;
    bias_weights();
`ifdef NEURON_RELU_EN
    run_directed("bias", 4, 32'd4);
`else
    run_directed("bias", 4, 32'd1);
`endif

    // Cancellation with wrapping products
    for (int c = 0; c < 8; c++) begin
      k = 32'(c) * 32'h3FFF_FFFF;
      for (int i = 0; i < 32; i++) td[i] = k;
      cycle();
      if (c >= 2) chk("cancel_sum", sum, 64'd4);
    end

    // Product wrap
    td = '0; tw = '0;
    td[0] = 32'h4000_0000; tw[0] = 32'd4;
    run_directed("wrap", 0, 32'd0);

    // Negative sum
    for (int i = 0; i < 32; i++) td[i] = 32'd1;
    tw = '1;
    run_directed("neg", -33, 32'd0);

    // Large positive sum
    for (int i = 0; i < 33; i++) tw[i] = 32'h7FFF_FFFF;
`ifdef NEURON_RELU_EN
    run_directed("sat", 64'h0000_0010_7FFF_FFDF, 32'h7FFF_FFFF);
`else
    run_directed("sat", 64'h0000_0010_7FFF_FFDF, 32'd1);
`endif

    // Valid gaps 1,0,1,1
    in_valid = 1'b1; rand_vec(1); cycle();
    in_valid = 1'b0; rand_vec(1); cycle();
    in_valid = 1'b1; rand_vec(1); cycle();
    in_valid = 1'b1; rand_vec(1); cycle();
    in_valid = 1'b0;
    repeat (4) cycle();

    // Reset mid-stream with three vectors in flight
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; rand_vec(1); cycle();
    end
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_sum", sum, 64'd0);
    chk("mid_rst_out", {32'd0, out}, 64'd0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    restart_model();
    in_valid = 1'b0;
    repeat (3) cycle();
    in_valid = 1'b1; rand_vec(1);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("post_rst_gap", {63'd0, out_valid}, 64'd0);
    cycle();
    chk("post_rst_first", {63'd0, out_valid}, 64'd1);

    // Random traffic
    for (int j = 0; j < 300; j++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      rand_vec((j % 3 == 0) ? 0 : 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
